// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared port indices, FSM encoding and one-hot helpers for the memory port arbiter.
package mem_arb_pkg;
   localparam logic [1:0] IF_PORT  = 2'd0;
   localparam logic [1:0] DAT_PORT = 2'd1;
   localparam logic [1:0] DBG_PORT = 2'd2;

   typedef enum logic {IDLE, BUSY} state_e;

   function automatic logic [2:0] onehot3(input logic [1:0] i);
      return 3'b001 << i;
   endfunction

   function automatic logic [1:0] idx3(input logic [2:0] oh);
      return oh[DBG_PORT] ? DBG_PORT : oh[DAT_PORT] ? DAT_PORT : IF_PORT;
   endfunction
endpackage

// File: rtl/mem_port_arb_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker with optional data-port override.
module rr_pick3
   import mem_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   input  logic       prio_en,
   output logic [2:0] pick
);
   logic [1:0] c1, c2;
   logic [3:0] r;
   always_comb begin
      r    = {1'b0, req};
      c1   = (last == DBG_PORT) ? IF_PORT : last + 2'd1;
      c2   = (c1 == DBG_PORT) ? IF_PORT : c1 + 2'd1;
      pick = (prio_en && req[DAT_PORT]) ? onehot3(DAT_PORT) :
             r[c1]   ? onehot3(c1)   :
             r[c2]   ? onehot3(c2)   :
             r[last] ? onehot3(last) : 3'b000;
   end
endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates the unified single-port memory between fetch, data and debug requesters,
// holding mem_en for LAT cycles per access and returning a done pulse plus read data to the owner.
module mem_port_arb
   import mem_arb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int LAT       = 2,
   parameter int DATA_PRIO = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    req,
   input  logic [2:0]    wr,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [AW-1:0] addr2,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic [DW-1:0] wdata2,
   output logic [2:0]    gnt,
   output logic [2:0]    done,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [1:0]    last_q, last_d, own_q, own_d, own_sel;
   logic [2:0]    gnt_q, gnt_d, done_q, done_d, pick;
   logic [DW-1:0] rdata_q, rdata_d, wdata_sel;
   logic [AW-1:0] addr_q, addr_d, addr_sel;
   logic [DW-1:0] wdat_q, wdat_d;
   logic          en_q, en_d, we_q, we_d;

   rr_pick3 u_pick (
      .req    (req),
      .last   (last_q),
      .prio_en(DATA_PRIO != 0),
      .pick   (pick)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      own_d     = own_q;
      gnt_d     = 3'b000;
      done_d    = 3'b000;
      rdata_d   = rdata_q;
      addr_d    = addr_q;
      wdat_d    = wdat_q;
      en_d      = en_q;
      we_d      = we_q;
      own_sel   = idx3(pick);
      addr_sel  = (own_sel == DBG_PORT) ? addr2 : (own_sel == DAT_PORT) ? addr1 : addr0;
      wdata_sel = (own_sel == DBG_PORT) ? wdata2 : (own_sel == DAT_PORT) ? wdata1 : wdata0;
      if (state_q == IDLE) begin
         if (req != 3'b000) begin
            state_d = BUSY;
            own_d   = own_sel;
            last_d  = own_sel;
            gnt_d   = pick;
            en_d    = 1'b1;
            we_d    = |(wr & pick);
            addr_d  = addr_sel;
            wdat_d  = wdata_sel;
            cnt_d   = 4'(LAT - 1);
         end
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         // mem_rdata is valid in the last enable cycle, i.e. at this edge
         state_d = IDLE;
         done_d  = onehot3(own_q);
         en_d    = 1'b0;
         we_d    = 1'b0;
         rdata_d = we_q ? rdata_q : mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         last_q  <= DBG_PORT;
         own_q   <= IF_PORT;
         gnt_q   <= 3'b000;
         done_q  <= 3'b000;
         rdata_q <= '0;
         addr_q  <= '0;
         wdat_q  <= '0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         own_q   <= own_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         en_q    <= en_d;
         we_q    <= we_d;
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign mem_en    = en_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdat_q;
endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbitrates the single-port unified memory of the multi-cycle CPU between three requesters: instruction fetch (port 0), load/store data (port 1) and debug/loader (port 2).
- Sequences each access over a fixed number of memory cycles.
- Returns completion pulses and read data to the owning requester.
- Sits between the control unit's fetch/memory phases and the memory macro.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 2, memory cycles per access (mem_en held LAT cycles), legal range 1..15.
- DATA_PRIO, 0, 1 = port 1 beats round-robin whenever requesting.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  3  per-port access request
- wr  in  3  per-port write enable (1 = write)
- addr0, addr1, addr2  in  AW each  per-port address
- wdata0, wdata1, wdata2  in  DW each  per-port write data
- gnt  out  3  one-hot, one-cycle pulse: request accepted
- done  out  3  one-hot, one-cycle pulse: access complete
- rdata  out  DW  read data, valid while done is high, holds afterwards
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in the LAT-th mem_en cycle

Behaviour:
- Reset values (applied immediately on rst):
  - state = IDLE, gnt = 0, done = 0, rdata = 0.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cnt = 0, last = 2, so port 0 has first priority after reset.
- FSM states: IDLE, BUSY.
- IDLE, req != 0 at a clock edge:
  - Pick owner.
  - Latch the owner's addr, wdata and wr into mem_addr, mem_wdata and mem_we.
  - Set mem_en = 1, cnt = LAT-1, gnt[owner] = 1, last = owner.
  - Next state is BUSY.
- IDLE, req == 0: all outputs except rdata stay idle.
- BUSY:
  - gnt clears after one cycle; req is ignored.
  - At each edge with cnt != 0: decrement cnt.
  - At the edge with cnt == 0:
    - If the access is a read, rdata <= mem_rdata; writes leave rdata unchanged.
    - done[owner] = 1 for one cycle; mem_en = 0, mem_we = 0.
    - Next state is IDLE.
- Pick rule:
  - If DATA_PRIO = 1 and req[1] is high: owner = 1.
  - Otherwise round-robin, searching last+1, last+2, last (mod 3).
- Timing: request sampled at edge E0 -> gnt in cycle 1 -> mem_en in cycles 1..LAT -> done in cycle LAT+1.
- Throughput: one access per LAT+1 cycles. The done cycle is IDLE, so arbitration happens at that edge (back-to-back).
- Requester rules:
  - Hold addr, wdata and wr stable while req is high and until gnt is seen.
  - Drop req in the cycle gnt is high. Any req high in an IDLE cycle is a new request.
- Simultaneous requests: exactly one is granted; the others stay pending, with no loss.
- With DATA_PRIO = 1, ports 0 and 2 can starve. This is intentional: the CPU never issues fetch and data accesses concurrently.
- Reset mid-access: the access is abandoned and no done is issued. A partially applied memory write is not undone.
- mem_* outputs are registered; no combinational path from req to mem_*.

Decomposition:
- Shared package mem_arb_pkg holds:
  - Port index constants IF_PORT = 0, DAT_PORT = 1, DBG_PORT = 2.
  - The state encoding IDLE/BUSY.
- Sub-module rr_pick3: combinational 3-way round-robin picker.
  - Inputs: req, last, prio_en.
  - Output: one-hot pick.
- Everything else lives in mem_port_arb.

Test Plan:
1. LAT=2, single read on port 0, addr0 = 0x100, memory returns 0xDEADBEEF -> gnt = 001 in cycle 1; mem_en = 1 with mem_addr = 0x100 in cycles 1-2; done = 001 in cycle 3 with rdata = 0xDEADBEEF.
2. LAT=2, DATA_PRIO=0, req = 111 re-asserted after each gnt -> grant order 0, 1, 2, 0, with gnt pulses spaced 3 cycles apart.
3. DATA_PRIO=1, req[0] and req[1] continuously pending -> port 1 wins every arbitration; gnt[0] never asserts over 20 accesses.
4. Write on port 2, addr2 = 0x20, wdata2 = 0x55, with rdata previously 0x1234 -> mem_we = 1, mem_addr = 0x20, mem_wdata = 0x55 for 2 cycles; done = 100; rdata stays 0x1234.
5. rst pulsed during the second BUSY cycle of a port 1 read -> mem_en, gnt and done go to 0 immediately with no done pulse; after release with req = 011, port 0 is granted first.
6. LAT=1, port 1 requests back-to-back -> gnt[1] every 2 cycles and done[1] one cycle after each gnt; no idle cycle between accesses.
